// File: rtl/step_sched_pkg.sv
// step_sched_pkg: shared channel state encoding and channel count for the
// step scheduler.
package step_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } ch_state_t;

  localparam int NUM_CH = 2;

endpackage

// File: rtl/step_scheduler_tick_prescaler.sv
// tick_prescaler: shared step-rate divider. Counts only while some channel
// is ACTIVE and fires one tick every period+1 cycles. The >= compare makes
// a period lowered mid-count wrap on the next cycle instead of running on
// to the counter's overflow.
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run & (cnt >= period);

  // Count while running, restart on each tick, hold at zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// step_scheduler: turns per-channel step requests into paced single-cycle
// ena strobes for the X/Y triangle generators. One shared tick is granted
// round-robin when both channels are ACTIVE.
// Optional feature macro: STEP_SCHEDULER_ABORT_EN adds the abort[1:0] input.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// ACTIVE | steps outstanding; waits for a granted tick
// DONE   | one-cycle finish marker; done high
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] period,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     req0_count,
  input  logic [N-1:0]     req1_count,
`ifdef STEP_SCHEDULER_ABORT_EN
  input  logic [1:0]       abort,
`endif
  output logic [1:0]       ena,
  output logic [1:0]       busy,
  output logic [1:0]       done
);

  ch_state_t        state     [NUM_CH];
  ch_state_t        state_nxt [NUM_CH];
  logic [N-1:0]     remaining     [NUM_CH];
  logic [N-1:0]     remaining_nxt [NUM_CH];
  logic [N-1:0]     req_count [NUM_CH];
  logic [1:0]       active;
  logic [1:0]       grant;
  logic [1:0]       abort_act;
  logic [1:0]       ena_nxt;
  logic             any_active;
  logic             tick;
  logic             rr;
  logic             rr_nxt;

  assign req_count[0] = req0_count;
  assign req_count[1] = req1_count;
  assign any_active   = |active;

`ifdef STEP_SCHEDULER_ABORT_EN
  assign abort_act = abort & active;
`else
  assign abort_act = 2'b00;
`endif

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .run    (any_active),
    .period (period),
    .tick   (tick)
  );

  // Status decode straight from channel state.
  always_comb begin
    active    = 2'b00;
    req_ready = 2'b00;
    busy      = 2'b00;
    done      = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i]    = (state[i] == ACTIVE);
      req_ready[i] = (state[i] == IDLE);
      busy[i]      = (state[i] != IDLE);
      done[i]      = (state[i] == DONE);
    end
  end

  // Tick arbitration; an aborted grant still consumes the tick and moves rr.
  always_comb begin
    grant = 2'b00;
    if (tick) begin
      if (active == 2'b11) begin
        grant[rr] = 1'b1;
      end else begin
        grant = active;
      end
    end
    rr_nxt = (|grant) ? ~rr : rr;
  end

  // Per-channel next-state, step countdown and strobe decode.
  always_comb begin
    ena_nxt = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i]     = state[i];
      remaining_nxt[i] = remaining[i];
      case (state[i])
        IDLE: begin
          if (req_valid[i]) begin
            remaining_nxt[i] = req_count[i];
            state_nxt[i]     = (req_count[i] == '0) ? DONE : ACTIVE;
          end
        end
        ACTIVE: begin
          if (abort_act[i]) begin
            state_nxt[i] = IDLE;
          end else if (grant[i]) begin
            ena_nxt[i]       = 1'b1;
            remaining_nxt[i] = remaining[i] - N'(1);
            if (remaining[i] == N'(1)) begin
              state_nxt[i] = DONE;
            end
          end
        end
        DONE:    state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // State, countdown, round-robin pointer and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]     <= IDLE;
        remaining[i] <= '0;
      end
      rr  <= 1'b0;
      ena <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]     <= state_nxt[i];
        remaining[i] <= remaining_nxt[i];
      end
      rr  <= rr_nxt;
      ena <= ena_nxt;
    end
  end

endmodule
